bus_user: RTL and testbench

BUS_USER -- requirements
Module: bus_user

---
 rtl/bus_user.sv | 49 ++++
 tb/tb_bus_user.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_user.sv
// rtl/bus_user.sv - three-state shared-bus user: transmit counter, bus capture, optional BUS_USER_CONTENTION_EN read-back detector
// Define BUS_USER_CONTENTION_EN to enable the sticky contention flag; otherwise contention is tied low.
module bus_user #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    inout  wire  [WIDTH-1:0] dbus,
    output logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_strobe,
    output logic             contention
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Drive enable is purely combinational so reset or grant loss releases the bus at once.
    assign dbus = (en && rst_n) ? tx_data : {WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data   <= '0;
            rx_data   <= '0;
            rx_strobe <= 1'b0;
        end else if (en) begin
            tx_data   <= tx_data + STEP_W;
            rx_strobe <= 1'b0;
        end else begin
            rx_data   <= dbus;
            rx_strobe <= 1'b1;
        end
    end

`ifdef BUS_USER_CONTENTION_EN
    // Case inequality so a floating or fought-over bit also flags a mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contention <= 1'b0;
        end else if (en && (dbus !== tx_data)) begin
            contention <= 1'b1;
        end
    end
`else
    assign contention = 1'b0;
`endif

endmodule

// File: tb/tb_bus_user.sv
// tb/tb_bus_user.sv - two bus_user instances on a shared 4-bit bus with a bench-side probe driver
module tb_bus_user;

    logic       clk;
    logic       rst_n;
    logic       en1, en2;
    logic       tb_en;
    logic [3:0] tb_val;
    wire  [3:0] dbus;
    logic [3:0] tx1, tx2, rx1, rx2;
    logic       st1, st2, ct1, ct2;

    int checks = 0;
    int errors = 0;

    // The bench drives a known pattern only when neither user should own the bus.
    assign dbus = tb_en ? tb_val : 4'bzzzz;

    bus_user u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .dbus(dbus),
        .tx_data(tx1), .rx_data(rx1), .rx_strobe(st1), .contention(ct1)
    );

    bus_user u2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .dbus(dbus),
        .tx_data(tx2), .rx_data(rx2), .rx_strobe(st2), .contention(ct2)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        en1 = 1'b0; en2 = 1'b0; tb_en = 1'b0; tb_val = 4'h0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx1, tx2, rx1, rx2} !== 16'h0000) begin
            errors++; $display("FAIL reset_data got %h expected 0000", {tx1, tx2, rx1, rx2});
        end
        checks++;
        if ({st1, st2, ct1, ct2} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b expected 0000", {st1, st2, ct1, ct2});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_drive();
        apply_reset();
        en1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (rx2 !== 4'(k) || st2 !== 1'b1) begin
                errors++; $display("FAIL single_rx k=%0d got rx=%h st=%b expected rx=%h st=1", k, rx2, st2, 4'(k));
            end
            checks++;
            if (st1 !== 1'b0) begin
                errors++; $display("FAIL single_tx_strobe k=%0d got %b expected 0", k, st1);
            end
        end
        checks++;
        if (tx1 !== 4'd5 || dbus !== 4'd5) begin
            errors++; $display("FAIL single_tx got tx=%h bus=%h expected 5 5", tx1, dbus);
        end
    endtask

    task automatic test_release();
        en1 = 1'b0; en2 = 1'b0;
        tb_en = 1'b1; tb_val = 4'hA;
        #1;
        checks++;
        if (dbus !== 4'hA) begin
            errors++; $display("FAIL release_bus got %h expected a (both users released)", dbus);
        end
        tick();
        tick();
        checks++;
        if (tx1 !== 4'd5 || tx2 !== 4'd0) begin
            errors++; $display("FAIL release_hold got tx1=%h tx2=%h expected 5 0", tx1, tx2);
        end
        checks++;
        if (rx1 !== 4'hA || rx2 !== 4'hA || st1 !== 1'b1) begin
            errors++; $display("FAIL release_rx got rx1=%h rx2=%h st1=%b expected a a 1", rx1, rx2, st1);
        end
        tb_en = 1'b0;
    endtask

    task automatic test_handover();
        apply_reset();
        en1 = 1'b1;
        repeat (5) tick();
        en1 = 1'b0; en2 = 1'b1;
        #1;
        checks++;
        if (dbus !== 4'd0) begin
            errors++; $display("FAIL handover_owner got %h expected 0", dbus);
        end
        repeat (3) tick();
        checks++;
        if (rx1 !== 4'd2 || tx2 !== 4'd3 || tx1 !== 4'd5 || rx2 !== 4'd4) begin
            errors++; $display("FAIL handover got rx1=%h tx2=%h tx1=%h rx2=%h expected 2 3 5 4", rx1, tx2, tx1, rx2);
        end
        checks++;
        if (dbus !== 4'd3) begin
            errors++; $display("FAIL handover_bus got %h expected 3", dbus);
        end
        en2 = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        en1 = 1'b1;
        repeat (16) tick();
        checks++;
        if (tx1 !== 4'd0) begin
            errors++; $display("FAIL wrap16 got %h expected 0", tx1);
        end
        tick();
        checks++;
        if (tx1 !== 4'd1) begin
            errors++; $display("FAIL wrap17 got %h expected 1", tx1);
        end
        en1 = 1'b0;
    endtask

    task automatic test_reset_mid_drive();
        apply_reset();
        en1 = 1'b1;
        repeat (7) tick();
        checks++;
        if (tx1 !== 4'd7 || dbus !== 4'd7) begin
            errors++; $display("FAIL middrive_pre got tx=%h bus=%h expected 7 7", tx1, dbus);
        end
        #3;
        rst_n = 1'b0;
        tb_en = 1'b1; tb_val = 4'hC;
        #1;
        checks++;
        if (tx1 !== 4'd0 || dbus !== 4'hC) begin
            errors++; $display("FAIL middrive_reset got tx=%h bus=%h expected 0 c", tx1, dbus);
        end
        tb_en = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (dbus !== 4'd0) begin
            errors++; $display("FAIL middrive_restart_bus got %h expected 0", dbus);
        end
        tick();
        checks++;
        if (tx1 !== 4'd1 || rx2 !== 4'd0) begin
            errors++; $display("FAIL middrive_restart got tx=%h rx2=%h expected 1 0", tx1, rx2);
        end
        en1 = 1'b0;
    endtask

    task automatic test_contention();
        logic exp_ct;
`ifdef BUS_USER_CONTENTION_EN
        exp_ct = 1'b1;
`else
        exp_ct = 1'b0;
`endif
        apply_reset();
        en1 = 1'b1;
        repeat (3) tick();
        checks++;
        if (tx1 !== 4'd3 || tx2 !== 4'd0 || ct1 !== 1'b0) begin
            errors++; $display("FAIL contention_setup got tx1=%h tx2=%h ct1=%b expected 3 0 0", tx1, tx2, ct1);
        end
        en2 = 1'b1;
        tick();
        en1 = 1'b0; en2 = 1'b0;
        tick();
        tick();
        checks++;
        if (ct1 !== exp_ct || ct2 !== exp_ct) begin
            errors++; $display("FAIL contention got %b%b expected %b%b", ct1, ct2, exp_ct, exp_ct);
        end
    endtask

    // Reference model: one owner per cycle (a user or the bench); non-owners latch whatever was on the bus.
    task automatic test_random();
        int m_tx[2];
        int m_rx[2];
        int m_st[2];
        int owner, bus_exp;
        apply_reset();
        m_tx = '{0, 0}; m_rx = '{0, 0}; m_st = '{0, 0};
        for (int i = 0; i < 200; i++) begin
            owner  = $urandom_range(0, 2);
            en1    = (owner == 1);
            en2    = (owner == 2);
            tb_en  = (owner == 0);
            tb_val = 4'($urandom_range(0, 15));
            bus_exp = (owner == 1) ? m_tx[0] : (owner == 2) ? m_tx[1] : int'(tb_val);
            #1;
            checks++;
            if (dbus !== 4'(bus_exp)) begin
                errors++; $display("FAIL rand_bus i=%0d got %h expected %h", i, dbus, 4'(bus_exp));
            end
            tick();
            for (int u = 0; u < 2; u++) begin
                if (owner == u + 1) begin
                    m_tx[u] = (m_tx[u] + 1) % 16;
                    m_st[u] = 0;
                end else begin
                    m_rx[u] = bus_exp;
                    m_st[u] = 1;
                end
            end
            checks++;
            if ({tx1, tx2} !== {4'(m_tx[0]), 4'(m_tx[1])}) begin
                errors++; $display("FAIL rand_tx i=%0d got %h%h expected %h%h", i, tx1, tx2, 4'(m_tx[0]), 4'(m_tx[1]));
            end
            checks++;
            if ({rx1, rx2} !== {4'(m_rx[0]), 4'(m_rx[1])}) begin
                errors++; $display("FAIL rand_rx i=%0d got %h%h expected %h%h", i, rx1, rx2, 4'(m_rx[0]), 4'(m_rx[1]));
            end
            checks++;
            if ({st1, st2, ct1, ct2} !== {1'(m_st[0]), 1'(m_st[1]), 2'b00}) begin
                errors++; $display("FAIL rand_flags i=%0d got %b expected %b%b00", i, {st1, st2, ct1, ct2}, 1'(m_st[0]), 1'(m_st[1]));
            end
        end
        en1 = 1'b0; en2 = 1'b0; tb_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0; tb_en = 1'b0; tb_val = 4'h0;
        test_reset();
        test_single_drive();
        test_release();
        test_handover();
        test_wrap();
        test_reset_mid_drive();
        test_contention();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
